// File: rtl/mul_feed_stage.sv
// Operand conditioning stage ahead of a combinational 32-bit multiplier.
// Registers truncated/shifted operands, then queues products in a small FIFO.
module mul_feed_stage #(
  parameter int SHIFT = 1,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic [31:0]              mul_a,
  output logic [31:0]              mul_b,
  input  logic [31:0]              mul_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int DATA_W = 32;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;

  function automatic logic [DATA_W-1:0] cond_op(input logic [15:0] x);
    logic [15:0] lo;
    lo = x >> SHIFT;
    return {16'b0, lo};
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] op_a_p1;
  logic [DATA_W-1:0] op_b_p1;
  logic [DATA_W-1:0] mem_p2 [DEPTH];
  logic [PW-1:0]     wptr_p2;
  logic [PW-1:0]     rptr_p2;
  logic [CW-1:0]     cnt_p2;

  logic accept, push, pop, full;
  logic unused_hi;

  // Upper operand halves are discarded by conditioning.
  assign unused_hi = ^{in_a[31:16], in_b[31:16]};

  assign full      = (cnt_p2 == CW'(DEPTH));
  assign res_valid = (cnt_p2 != '0);
  assign pop       = res_valid && res_ready;
  assign push      = vld_p1 && (!full || pop);
  assign in_ready  = !vld_p1 || push;
  assign accept    = in_valid && in_ready;

  assign mul_a    = op_a_p1;
  assign mul_b    = op_b_p1;
  assign res_data = mem_p2[rptr_p2];
  assign count    = cnt_p2;

  // Stage 1: conditioned operands presented to the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      op_a_p1 <= '0;
      op_b_p1 <= '0;
    end else begin
      if (accept) begin
        vld_p1  <= 1'b1;
        op_a_p1 <= cond_op(in_a[15:0]);
        op_b_p1 <= cond_op(in_b[15:0]);
      end else if (push) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Stage 2: product FIFO; full/empty resolved by occupancy, pointers wrap freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_p2 <= '0;
      rptr_p2 <= '0;
      cnt_p2  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_p2[i] <= '0;
    end else begin
      if (push) begin
        mem_p2[wptr_p2] <= mul_out;
        wptr_p2         <= wptr_p2 + PW'(1);
      end
      if (pop) rptr_p2 <= rptr_p2 + PW'(1);
      case ({push, pop})
        2'b10:   cnt_p2 <= cnt_p2 + CW'(1);
        2'b01:   cnt_p2 <= cnt_p2 - CW'(1);
        default: cnt_p2 <= cnt_p2;
      endcase
    end
  end

endmodule
